// File: rtl/addsub_pkg.sv
// Shared types and helpers for the signed add/subtract accumulator datapath.
// Provides the operation encoding and signed range limits for any width.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_e;

    // Limits are returned at 64 bits; callers keep the low width bits they need.
    function automatic logic signed [63:0] smax(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] smin(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/signed_addsub_sat.sv
// Combinational signed add/subtract with overflow detection and optional clamping.
// The operation is done one bit wider so that subtracting the minimum value is exact.
module signed_addsub_sat
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] sum,
    output logic                    ovf
);

    localparam logic signed [63:0]      MAX64 = smax(WIDTH);
    localparam logic signed [63:0]      MIN64 = smin(WIDTH);
    localparam logic signed [WIDTH-1:0] SMAX  = MAX64[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] SMIN  = MIN64[WIDTH-1:0];

    logic signed [WIDTH:0] xe;
    logic signed [WIDTH:0] ye;
    logic signed [WIDTH:0] ext;

    assign xe  = {x[WIDTH-1], x};
    assign ye  = {y[WIDTH-1], y};
    assign ext = sub ? (xe - ye) : (xe + ye);
    assign ovf = ext[WIDTH] != ext[WIDTH-1];

    // The extended sign bit tells the true direction of an overflow.
    always_comb begin
        sum = ext[WIDTH-1:0];
        if (SATURATE && ovf) begin
            sum = ext[WIDTH] ? SMIN : SMAX;
        end
    end

endmodule

// File: rtl/signed_addsub_acc.sv
// Registered signed add/subtract unit with valid/ready handshake and an internal accumulator.
// One output register stage; a new beat may be taken in the same cycle the old result is consumed.
module signed_addsub_acc
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic [1:0]              op,
    input  logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] result,
    output logic                    overflow,
    output logic signed [WIDTH-1:0] acc
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;

    op_e                     op_sel;
    logic                    accept;
    logic                    is_acc_op;
    logic signed [WIDTH-1:0] acc_operand;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] sum;
    logic                    ovf;

    assign op_sel    = op_e'(op);
    assign is_acc_op = (op_sel == OP_ACC_ADD) || (op_sel == OP_ACC_SUB);
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // A clear in the same cycle as an accumulate op makes that op start from zero.
    assign acc_operand = acc_clr ? '0 : acc;
    assign x = is_acc_op ? acc_operand : a;
    assign y = is_acc_op ? a : b;

    signed_addsub_sat #(
        .WIDTH   (WIDTH),
        .SATURATE(SATURATE)
    ) u_addsub (
        .x  (x),
        .y  (y),
        .sub(op[0]),
        .sum(sum),
        .ovf(ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            result   <= sum;
            overflow <= ovf;
        end
    end

    // The accumulator keeps the post-saturation/wrap value, matching what was reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && is_acc_op) begin
            acc <= sum;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

endmodule
